write_en_sequencer: RTL and testbench

Parametrised, registered successor to the fixed 7-destination write-enable decoder. Accepts a write request over a valid/ready handshake, either to a single destination index or to a destination mask. Issues one-hot write enables, one destination per cycle in ascending index order, with the request data held on a shared write bus. Sits between the control unit and the register bank (PC, DR, R1..Rn), with out-of-range/empty detection, flush and a saturating write counter.

---
 rtl/write_en_pkg.sv | 32 +++
 rtl/lowbit_pick.sv | 28 ++
 rtl/write_en_sequencer.sv | 136 +++++++++++++
 tb/tb_write_en_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/write_en_pkg.sv
// Shared constants, state encoding and request-mask helper for the
// write-enable sequencer.
package write_en_pkg;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_MASK   = 1'b1;

   localparam int IDX_PC = 0;
   localparam int IDX_DR = 1;
   localparam int IDX_R1 = 2;

   // Widest destination set the mask helper can represent.
   localparam int MAX_DEST = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } seq_state_t;

   // Single-destination mask; all-zero when the index is out of range,
   // so a zero result marks the request invalid.
   function automatic logic [MAX_DEST-1:0] single_mask(input logic [31:0] sel,
                                                       input int          num_dest);
      logic [MAX_DEST-1:0] m;
      m = '0;
      if (sel < 32'(num_dest)) begin
         m[sel[4:0]] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/lowbit_pick.sv
// Combinational priority picker: isolates the lowest set bit of a mask,
// reports its index and the mask with that bit removed.
module lowbit_pick #(
   parameter int W     = 7,
   parameter int IDX_W = 3
) (
   input  logic [W-1:0]     mask,
   output logic [W-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic [W-1:0]     rest,
   output logic             any
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (mask[i] && !any) begin
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
            any       = 1'b1;
         end
      end
      rest = mask & ~onehot;
   end

endmodule

// File: rtl/write_en_sequencer.sv
// Registered write-enable sequencer: accepts a single-index or mask request
// and issues one-hot write enables in ascending index order.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | pending == 0, request can be accepted (unless flush/reset)
// ST_ISSUE | pending != 0, one destination issued per cycle
module write_en_sequencer
   import write_en_pkg::*;
#(
   parameter int NUM_DEST = 7,
   parameter int SEL_W    = 3,
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_mode,
   input  logic [SEL_W-1:0]    req_sel,
   input  logic [NUM_DEST-1:0] req_mask,
   input  logic [DATA_W-1:0]   req_data,
   output logic [NUM_DEST-1:0] wr_en,
   output logic [SEL_W-1:0]    wr_idx,
   output logic [DATA_W-1:0]   wr_data,
   output logic                done,
   output logic                err,
   output logic                busy,
   output logic [CNT_W-1:0]    wr_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_DEST-1:0] pending;
   logic [NUM_DEST-1:0] req_mask_eff;
   seq_state_t          state;

   logic [NUM_DEST-1:0] acc_onehot, acc_rest;
   logic [SEL_W-1:0]    acc_idx;
   logic                acc_any;

   logic [NUM_DEST-1:0] iss_onehot, iss_rest;
   logic [SEL_W-1:0]    iss_idx;
   logic                iss_any;

   logic                issue_fire;

   always_comb begin
      req_mask_eff = req_mask;
      if (req_mode == MODE_SINGLE) begin
         req_mask_eff = NUM_DEST'(single_mask(32'(req_sel), NUM_DEST));
      end
   end

   lowbit_pick #(.W(NUM_DEST), .IDX_W(SEL_W)) u_pick_accept (
      .mask   (req_mask_eff),
      .onehot (acc_onehot),
      .idx    (acc_idx),
      .rest   (acc_rest),
      .any    (acc_any)
   );

   lowbit_pick #(.W(NUM_DEST), .IDX_W(SEL_W)) u_pick_issue (
      .mask   (pending),
      .onehot (iss_onehot),
      .idx    (iss_idx),
      .rest   (iss_rest),
      .any    (iss_any)
   );

   assign state     = (pending != '0) ? ST_ISSUE : ST_IDLE;
   assign req_ready = !reset && !flush && (state == ST_IDLE);
   assign busy      = (pending != '0) || (wr_en != '0);

   // True on edges that load a nonzero wr_en; drives the write counter.
   always_comb begin
      issue_fire = 1'b0;
      if (!flush) begin
         if (state == ST_ISSUE) begin
            issue_fire = iss_any;
         end else begin
            issue_fire = req_valid && acc_any;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         wr_en    <= '0;
         wr_idx   <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         wr_count <= '0;
      end else begin
         wr_en <= '0;
         done  <= 1'b0;
         err   <= 1'b0;

         if (flush) begin
            pending <= '0;
         end else begin
            unique case (state)
               ST_ISSUE: begin
                  wr_en   <= iss_onehot;
                  wr_idx  <= iss_idx;
                  pending <= iss_rest;
                  done    <= (iss_rest == '0);
               end
               ST_IDLE: begin
                  if (req_valid) begin
                     if (acc_any) begin
                        wr_en   <= acc_onehot;
                        wr_idx  <= acc_idx;
                        wr_data <= req_data;
                        pending <= acc_rest;
                        done    <= (acc_rest == '0);
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               default: pending <= '0;
            endcase
         end

         if (issue_fire && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_write_en_sequencer.sv
// Directed bench: expected outputs queued per driven cycle and compared after
// each edge; a second instance with a 2-bit counter covers saturation.
module tb_write_en_sequencer;
   import write_en_pkg::*;

   logic       clk = 1'b0;
   logic       reset, flush, req_valid, req_mode;
   logic [2:0] req_sel;
   logic [6:0] req_mask;
   logic [7:0] req_data;

   logic        req_ready, done, err, busy;
   logic [6:0]  wr_en;
   logic [2:0]  wr_idx;
   logic [7:0]  wr_data;
   logic [15:0] wr_count;

   logic       s_ready, s_done, s_err, s_busy;
   logic [6:0] s_wr_en;
   logic [2:0] s_wr_idx;
   logic [7:0] s_wr_data;
   logic [1:0] s_wr_count;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [6:0]  en;
      logic [2:0]  idx;
      logic [7:0]  data;
      logic        done;
      logic        err;
      logic        busy;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   write_en_sequencer dut (
      .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
      .req_ready(req_ready), .req_mode(req_mode), .req_sel(req_sel),
      .req_mask(req_mask), .req_data(req_data), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_data(wr_data), .done(done), .err(err), .busy(busy), .wr_count(wr_count)
   );

   write_en_sequencer #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
      .req_ready(s_ready), .req_mode(req_mode), .req_sel(req_sel),
      .req_mask(req_mask), .req_data(req_data), .wr_en(s_wr_en), .wr_idx(s_wr_idx),
      .wr_data(s_wr_data), .done(s_done), .err(s_err), .busy(s_busy),
      .wr_count(s_wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic [6:0] en, input logic [2:0] idx,
                       input logic [7:0] data, input logic dn, input logic er,
                       input logic bz, input logic [15:0] cnt);
      exp_t e;
      e.tag = tag; e.en = en; e.idx = idx; e.data = data;
      e.done = dn; e.err = er; e.busy = bz; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic mode, input logic [2:0] sel,
                        input logic [6:0] mask, input logic [7:0] data);
      req_valid = v; req_mode = mode; req_sel = sel; req_mask = mask; req_data = data;
   endtask

   // Advance one edge, then compare outputs against the oldest queued entry.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, ".wr_en"},    32'(wr_en),    32'(e.en));
         chk({e.tag, ".wr_data"},  32'(wr_data),  32'(e.data));
         chk({e.tag, ".done"},     32'(done),     32'(e.done));
         chk({e.tag, ".err"},      32'(err),      32'(e.err));
         chk({e.tag, ".busy"},     32'(busy),     32'(e.busy));
         chk({e.tag, ".wr_count"}, 32'(wr_count), 32'(e.cnt));
         if (e.en != '0) chk({e.tag, ".wr_idx"}, 32'(wr_idx), 32'(e.idx));
      end
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      reset = 1'b1; flush = 1'b0;
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'd0);

      // Reset
      push("reset", 7'd0, 3'd0, 8'h00, 0, 0, 0, 16'd0);
      tick();
      chk("reset.wr_idx", 32'(wr_idx), 32'd0);
      chk("reset.ready_low", 32'(req_ready), 32'd0);
      chk("reset.sat_count", 32'(s_wr_count), 32'd0);
      reset = 1'b0;
      push("idle0", 7'd0, 3'd0, 8'h00, 0, 0, 0, 16'd0);
      tick();
      chk("idle0.ready", 32'(req_ready), 32'd1);

      // Single write, idx 3
      drive(1'b1, MODE_SINGLE, 3'd3, 7'd0, 8'hA5);
      push("single3", 7'b0001000, 3'd3, 8'hA5, 1, 0, 1, 16'd1);
      tick();
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("single3.after", 7'd0, 3'd0, 8'hA5, 0, 0, 0, 16'd1);
      tick();

      // Mask request, held valid with changed data while stalled
      drive(1'b1, MODE_MASK, 3'd0, 7'b1010010, 8'h3C);
      push("mask.b1", 7'b0000010, 3'd1, 8'h3C, 0, 0, 1, 16'd2);
      tick();
      chk("mask.ready_low1", 32'(req_ready), 32'd0);
      req_data = 8'hFF;
      push("mask.b4", 7'b0010000, 3'd4, 8'h3C, 0, 0, 1, 16'd3);
      tick();
      chk("mask.ready_low2", 32'(req_ready), 32'd0);
      push("mask.b6", 7'b1000000, 3'd6, 8'h3C, 1, 0, 1, 16'd4);
      tick();
      chk("mask.ready_high", 32'(req_ready), 32'd1);
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("mask.after", 7'd0, 3'd0, 8'h3C, 0, 0, 0, 16'd4);
      tick();

      // Invalid requests
      drive(1'b1, MODE_SINGLE, 3'd7, 7'd0, 8'h99);
      push("err.sel7", 7'd0, 3'd0, 8'h3C, 0, 1, 0, 16'd4);
      tick();
      drive(1'b1, MODE_MASK, 3'd0, 7'd0, 8'h98);
      push("err.mask0", 7'd0, 3'd0, 8'h3C, 0, 1, 0, 16'd4);
      tick();
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("err.after", 7'd0, 3'd0, 8'h3C, 0, 0, 0, 16'd4);
      tick();

      // Back-to-back singles PC, DR, R1
      drive(1'b1, MODE_SINGLE, 3'(IDX_PC), 7'd0, 8'h11);
      push("b2b.pc", 7'b0000001, 3'd0, 8'h11, 1, 0, 1, 16'd5);
      tick();
      drive(1'b1, MODE_SINGLE, 3'(IDX_DR), 7'd0, 8'h22);
      push("b2b.dr", 7'b0000010, 3'd1, 8'h22, 1, 0, 1, 16'd6);
      tick();
      drive(1'b1, MODE_SINGLE, 3'(IDX_R1), 7'd0, 8'h33);
      push("b2b.r1", 7'b0000100, 3'd2, 8'h33, 1, 0, 1, 16'd7);
      tick();
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("b2b.after", 7'd0, 3'd0, 8'h33, 0, 0, 0, 16'd7);
      tick();

      // Full mask flushed during third issue cycle
      drive(1'b1, MODE_MASK, 3'd0, 7'b1111111, 8'h5A);
      push("flush.b0", 7'b0000001, 3'd0, 8'h5A, 0, 0, 1, 16'd8);
      tick();
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("flush.b1", 7'b0000010, 3'd1, 8'h5A, 0, 0, 1, 16'd9);
      tick();
      flush = 1'b1;
      push("flush.cut", 7'd0, 3'd0, 8'h5A, 0, 0, 0, 16'd9);
      tick();
      flush = 1'b0;
      #1;
      chk("flush.ready_after", 32'(req_ready), 32'd1);
      push("flush.idle", 7'd0, 3'd0, 8'h5A, 0, 0, 0, 16'd9);
      tick();

      // Flush coincident with a valid request drops it
      flush = 1'b1;
      drive(1'b1, MODE_SINGLE, 3'd3, 7'd0, 8'h77);
      #1;
      chk("flushreq.ready_low", 32'(req_ready), 32'd0);
      push("flushreq.drop", 7'd0, 3'd0, 8'h5A, 0, 0, 0, 16'd9);
      tick();
      flush = 1'b0;
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("flushreq.after", 7'd0, 3'd0, 8'h5A, 0, 0, 0, 16'd9);
      tick();

      // Saturation on the 2-bit counter instance
      reset = 1'b1;
      push("reset2", 7'd0, 3'd0, 8'h00, 0, 0, 0, 16'd0);
      tick();
      chk("reset2.sat_count", 32'(s_wr_count), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, MODE_SINGLE, 3'(i), 7'd0, 8'(i + 1));
         push($sformatf("sat%0d", i), 7'(1 << i), 3'(i), 8'(i + 1), 1, 0, 1, 16'(i + 1));
         tick();
         chk($sformatf("sat%0d.sat_count", i), 32'(s_wr_count), 32'(sat_exp[i]));
      end
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      push("sat.after", 7'd0, 3'd0, 8'h05, 0, 0, 0, 16'd5);
      tick();

      // Reset in the middle of a mask sequence
      drive(1'b1, MODE_MASK, 3'd0, 7'b0111000, 8'hC3);
      push("rstmid.b3", 7'b0001000, 3'd3, 8'hC3, 0, 0, 1, 16'd6);
      tick();
      drive(1'b0, MODE_SINGLE, 3'd0, 7'd0, 8'h00);
      reset = 1'b1;
      push("rstmid.reset", 7'd0, 3'd0, 8'h00, 0, 0, 0, 16'd0);
      tick();
      chk("rstmid.wr_idx", 32'(wr_idx), 32'd0);
      chk("rstmid.sat_count", 32'(s_wr_count), 32'd0);
      reset = 1'b0;
      push("rstmid.idle", 7'd0, 3'd0, 8'h00, 0, 0, 0, 16'd0);
      tick();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
